// File: rtl/mem_test_axi_pkg.sv
// Shared types and constant helpers for the memory-tester AXI responder.
package mem_test_axi_pkg;

  // Write channel: address accepted, data beats, then write response.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Read channel: address accepted, then beats streamed out.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Number of byte-offset address bits inside one data word.
  function automatic int beat_byte_log2(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Width of a RAM word index; a one-word RAM still needs a one-bit index.
  function automatic int index_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/mem_test_axi_bram.sv
// Simple dual-port RAM: byte-enabled write port, read-first registered read port.
module mem_test_axi_bram #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Byte-lane writes; lanes with a clear strobe keep their old contents.
  // NOTE: the storage array is deliberately not reset -- it must survive areset and map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Next read register value: fetch on rd_en, otherwise hold (stall-safe).
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_idx];
    end
  end

  // Read register; sampling the array before this edge's write lands makes it read-first.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_test_axi_responder.sv
// AXI4 slave memory responder for the memory-tester kernel's reduced master port.
module mem_test_axi_responder
  import mem_test_axi_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 256,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic [31:0]                     wr_burst_count,
  output logic [31:0]                     rd_burst_count,
  output logic                            proto_err
);

  localparam int BYTE_LSB = beat_byte_log2(C_S_AXI_DATA_WIDTH);
  localparam int IDX_W    = index_width(C_MEM_DEPTH_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  // Write channel state.
  wr_state_t        wr_state_d, wr_state_q;
  logic [IDX_W-1:0] wr_idx_d, wr_idx_q;
  logic [7:0]       wr_cnt_d, wr_cnt_q;
  logic [31:0]      wr_burst_count_d, wr_burst_count_q;
  logic             proto_err_d, proto_err_q;
  logic             ram_wr_en;

  // Read channel state; rd_left counts beats not yet fetched (up to 256).
  rd_state_t        rd_state_d, rd_state_q;
  logic [IDX_W-1:0] rd_idx_d, rd_idx_q;
  logic [8:0]       rd_left_d, rd_left_q;
  logic             rvalid_d, rvalid_q;
  logic             rlast_d, rlast_q;
  logic [31:0]      rd_burst_count_d, rd_burst_count_q;
  logic             ram_rd_en;
  logic             rd_take;

  // Address bits outside the word index alias and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // Handshake flags decode straight from registered state; address ready is held low in reset.
  assign s_axi_awready = (wr_state_q == W_IDLE) && !areset;
  assign s_axi_wready  = (wr_state_q == W_DATA);
  assign s_axi_bvalid  = (wr_state_q == W_RESP);
  assign s_axi_arready = (rd_state_q == R_IDLE) && !areset;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign wr_burst_count = wr_burst_count_q;
  assign rd_burst_count = rd_burst_count_q;
  assign proto_err      = proto_err_q;

  assign rd_take = rvalid_q && s_axi_rready;

  // Write FSM next state: burst length follows awlen; wlast is only checked.
  always_comb begin
    wr_state_d       = wr_state_q;
    wr_idx_d         = wr_idx_q;
    wr_cnt_d         = wr_cnt_q;
    wr_burst_count_d = wr_burst_count_q;
    proto_err_d      = proto_err_q;
    ram_wr_en        = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          wr_idx_d   = s_axi_awaddr[BYTE_LSB +: IDX_W];
          wr_cnt_d   = s_axi_awlen;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          ram_wr_en = 1'b1;
          wr_idx_d  = wr_idx_q + IDX_ONE;
          wr_cnt_d  = wr_cnt_q - 8'd1;
          if (s_axi_wlast != (wr_cnt_q == 8'd0)) begin
            proto_err_d = 1'b1;
          end
          if (wr_cnt_q == 8'd0) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wr_burst_count_d = wr_burst_count_q + 32'd1;
          wr_state_d       = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers; reset abandons any burst but keeps the RAM.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_state_q       <= W_IDLE;
      wr_idx_q         <= '0;
      wr_cnt_q         <= '0;
      wr_burst_count_q <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      wr_state_q       <= wr_state_d;
      wr_idx_q         <= wr_idx_d;
      wr_cnt_q         <= wr_cnt_d;
      wr_burst_count_q <= wr_burst_count_d;
      proto_err_q      <= proto_err_d;
    end
  end

  // Read FSM next state: refill the output register whenever it is empty or draining.
  always_comb begin
    rd_state_d       = rd_state_q;
    rd_idx_d         = rd_idx_q;
    rd_left_d        = rd_left_q;
    rvalid_d         = rvalid_q;
    rlast_d          = rlast_q;
    rd_burst_count_d = rd_burst_count_q;
    ram_rd_en        = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rd_idx_d   = s_axi_araddr[BYTE_LSB +: IDX_W];
          rd_left_d  = {1'b0, s_axi_arlen} + 9'd1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rd_take) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            rd_burst_count_d = rd_burst_count_q + 32'd1;
            rd_state_d       = R_IDLE;
          end
        end
        if ((rd_left_q != 9'd0) && (!rvalid_q || rd_take)) begin
          ram_rd_en = 1'b1;
          rd_idx_d  = rd_idx_q + IDX_ONE;
          rd_left_d = rd_left_q - 9'd1;
          rvalid_d  = 1'b1;
          rlast_d   = (rd_left_q == 9'd1);
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers; the RAM read register doubles as the rdata output register.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rd_state_q       <= R_IDLE;
      rd_idx_q         <= '0;
      rd_left_q        <= '0;
      rvalid_q         <= 1'b0;
      rlast_q          <= 1'b0;
      rd_burst_count_q <= '0;
    end else begin
      rd_state_q       <= rd_state_d;
      rd_idx_q         <= rd_idx_d;
      rd_left_q        <= rd_left_d;
      rvalid_q         <= rvalid_d;
      rlast_q          <= rlast_d;
      rd_burst_count_q <= rd_burst_count_d;
    end
  end

  mem_test_axi_bram #(
    .DATA_W (C_S_AXI_DATA_WIDTH),
    .DEPTH  (C_MEM_DEPTH_WORDS),
    .IDX_W  (IDX_W)
  ) u_bram (
    .clk     (ap_clk),
    .rst     (areset),
    .wr_en   (ram_wr_en),
    .wr_idx  (wr_idx_q),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_en   (ram_rd_en),
    .rd_idx  (rd_idx_q),
    .rd_data (s_axi_rdata)
  );

endmodule

// File: tb/tb_mem_test_axi_responder.sv
// Scoreboard bench for mem_test_axi_responder: reads push expected beats, a monitor pops them.
module tb_mem_test_axi_responder;

  localparam int AW = 64;
  localparam int DW = 256;
  localparam int SW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rbeat_t;

  logic          ap_clk = 1'b0;
  logic          areset;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [SW-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic [31:0]   wr_burst_count, rd_burst_count;
  logic          proto_err;

  int n_cmp = 0;
  int n_err = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  rbeat_t        exp_q[$];
  rbeat_t        mon_e;
  logic          mon_ignore = 1'b0;
  logic          mon_stall_prev = 1'b0;
  logic [DW-1:0] mon_data_prev;
  logic          mon_last_prev;

  logic [DW-1:0] wr_beats [16];
  logic [SW-1:0] wr_strb;
  logic [DW-1:0] rd_exp [16];

  logic       rr_toggle = 1'b0;
  logic [3:0] rr_pat = 4'b1001;
  int         rr_k = 0;

  always #5 ap_clk = ~ap_clk;

  mem_test_axi_responder dut (
    .ap_clk         (ap_clk),
    .areset         (areset),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awlen    (s_axi_awlen),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wlast    (s_axi_wlast),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_bready   (s_axi_bready),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arlen    (s_axi_arlen),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rlast    (s_axi_rlast),
    .wr_burst_count (wr_burst_count),
    .rd_burst_count (rd_burst_count),
    .proto_err      (proto_err)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // rready driver: constant 1, or the 1,0,0,1 stall pattern.
  initial begin
    s_axi_rready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      if (rr_toggle) begin
        s_axi_rready = rr_pat[rr_k];
        rr_k = (rr_k + 1) % 4;
      end else begin
        s_axi_rready = 1'b1;
      end
    end
  end

  // Monitor: compare each accepted R beat with the scoreboard; check stall stability.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (areset || mon_ignore) begin
        mon_stall_prev = 1'b0;
      end else begin
        if (mon_stall_prev) begin
          check("r_hold_valid", DW'(s_axi_rvalid), DW'(1'b1));
          check("r_hold_data", s_axi_rdata, mon_data_prev);
          check("r_hold_last", DW'(s_axi_rlast), DW'(mon_last_prev));
        end
        if (s_axi_rvalid && s_axi_rready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL r_extra: got beat %h, required no beat", s_axi_rdata);
          end else begin
            mon_e = exp_q.pop_front();
            check("r_data", s_axi_rdata, mon_e.data);
            check("r_last", DW'(s_axi_rlast), DW'(mon_e.last));
          end
        end
        mon_stall_prev = s_axi_rvalid && !s_axi_rready;
        mon_data_prev  = s_axi_rdata;
        mon_last_prev  = s_axi_rlast;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic wait_awready();
    int n = 0;
    @(negedge ap_clk);
    while (!s_axi_awready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    check("aw_ready", DW'(s_axi_awready), DW'(1'b1));
  endtask

  task automatic wait_arready();
    int n = 0;
    @(negedge ap_clk);
    while (!s_axi_arready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    check("ar_ready", DW'(s_axi_arready), DW'(1'b1));
  endtask

  // Write burst from wr_beats/wr_strb; early_last >= 0 puts wlast on that beat instead.
  task automatic write_burst(input logic [AW-1:0] addr, input int len, input int early_last);
    @(posedge ap_clk);
    #1;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    wait_awready();
    @(posedge ap_clk);
    #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wr_beats[i];
      s_axi_wstrb  = wr_strb;
      s_axi_wlast  = (early_last >= 0) ? (i == early_last) : (i == len);
      @(negedge ap_clk);
      check("w_ready", DW'(s_axi_wready), DW'(1'b1));
      if (i > 0) check("b_early", DW'(s_axi_bvalid), DW'(1'b0));
      @(posedge ap_clk);
      #1;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    s_axi_bready = 1'b1;
    @(negedge ap_clk);
    check("b_valid", DW'(s_axi_bvalid), DW'(1'b1));
    @(posedge ap_clk);
    #1;
    s_axi_bready = 1'b0;
    exp_wr++;
    @(negedge ap_clk);
    check("wr_count", DW'(wr_burst_count), DW'(exp_wr));
    check("b_done", DW'(s_axi_bvalid), DW'(1'b0));
  endtask

  // Read burst: push rd_exp[0..len] into the scoreboard, then issue AR and drain.
  task automatic read_burst(input logic [AW-1:0] addr, input int len);
    int n = 0;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back('{data: rd_exp[i], last: (i == len)});
    end
    @(posedge ap_clk);
    #1;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    wait_arready();
    @(posedge ap_clk);
    #1;
    s_axi_arvalid = 1'b0;
    @(negedge ap_clk);
    check("r_lat_t1", DW'(s_axi_rvalid), DW'(1'b0));
    @(negedge ap_clk);
    check("r_lat_t2", DW'(s_axi_rvalid), DW'(1'b1));
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    check("r_drain", DW'(exp_q.size()), DW'(0));
    exp_rd++;
    @(negedge ap_clk);
    check("rd_count", DW'(rd_burst_count), DW'(exp_rd));
  endtask

  initial begin
    areset        = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awlen   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wlast   = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    wr_strb       = '1;

    // Reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_awready", DW'(s_axi_awready), DW'(1'b0));
    check("rst_arready", DW'(s_axi_arready), DW'(1'b0));
    check("rst_rvalid", DW'(s_axi_rvalid), DW'(1'b0));
    check("rst_bvalid", DW'(s_axi_bvalid), DW'(1'b0));
    check("rst_rlast", DW'(s_axi_rlast), DW'(1'b0));
    check("rst_rdata", s_axi_rdata, '0);
    check("rst_wr_count", DW'(wr_burst_count), DW'(0));
    check("rst_rd_count", DW'(rd_burst_count), DW'(0));
    check("rst_proto", DW'(proto_err), DW'(1'b0));
    @(posedge ap_clk);
    #1;
    areset = 1'b0;
    @(negedge ap_clk);
    check("rel_awready", DW'(s_axi_awready), DW'(1'b1));
    check("rel_arready", DW'(s_axi_arready), DW'(1'b1));
    check("rel_wready", DW'(s_axi_wready), DW'(1'b0));

    // Burst of 4 at address 0, data 1..4
    for (int i = 0; i < 4; i++) begin
      wr_beats[i] = DW'(i + 1);
      rd_exp[i]   = DW'(i + 1);
    end
    write_burst(64'h0, 3, -1);
    read_burst(64'h0, 3);

    // Partial strobe on word 8: low 4 bytes 0xFF over 0xAA
    wr_beats[0] = {32{8'hAA}};
    write_burst(64'h100, 0, -1);
    wr_beats[0] = {32{8'hFF}};
    wr_strb     = 32'h0000_000F;
    write_burst(64'h100, 0, -1);
    wr_strb     = '1;
    rd_exp[0]   = {{28{8'hAA}}, {4{8'hFF}}};
    read_burst(64'h100, 0);

    // Wrap from word 1022: aliased upper bits and unaligned low bits on AW
    for (int i = 0; i < 8; i++) begin
      wr_beats[i] = DW'(32'h100 + i);
      rd_exp[i]   = DW'(32'h100 + i);
    end
    write_burst(64'hF000_0000_0000_7FC5, 7, -1);
    read_burst(64'h7FC0, 7);
    for (int i = 0; i < 6; i++) rd_exp[i] = DW'(32'h102 + i);
    read_burst(64'h0, 5);

    // 16-beat read with rready stalls 1,0,0,1
    for (int i = 0; i < 16; i++) begin
      wr_beats[i] = DW'(32'h200 + i);
      rd_exp[i]   = DW'(32'h200 + i);
    end
    write_burst(64'h200, 15, -1);
    check("proto_clean", DW'(proto_err), DW'(1'b0));
    rr_k      = 0;
    rr_toggle = 1'b1;
    read_burst(64'h200, 15);
    rr_toggle = 1'b0;

    // wlast on beat 2 of a 4-beat burst: error flagged, 4 beats still written
    for (int i = 0; i < 4; i++) begin
      wr_beats[i] = DW'(32'h300 + i);
      rd_exp[i]   = DW'(32'h300 + i);
    end
    write_burst(64'h500, 3, 1);
    check("proto_set", DW'(proto_err), DW'(1'b1));
    read_burst(64'h500, 3);
    check("proto_sticky", DW'(proto_err), DW'(1'b1));

    // Reset in the middle of a read burst
    mon_ignore = 1'b1;
    @(posedge ap_clk);
    #1;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = 64'h200;
    s_axi_arlen   = 8'd15;
    wait_arready();
    @(posedge ap_clk);
    #1;
    s_axi_arvalid = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    areset = 1'b1;
    @(negedge ap_clk);
    check("mid_rst_arready", DW'(s_axi_arready), DW'(1'b0));
    @(negedge ap_clk);
    check("mid_rst_rvalid", DW'(s_axi_rvalid), DW'(1'b0));
    check("mid_rst_rlast", DW'(s_axi_rlast), DW'(1'b0));
    check("mid_rst_rdata", s_axi_rdata, '0);
    check("mid_rst_rd_count", DW'(rd_burst_count), DW'(0));
    check("mid_rst_proto", DW'(proto_err), DW'(1'b0));
    @(posedge ap_clk);
    #1;
    areset = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    @(negedge ap_clk);
    check("post_rst_arready", DW'(s_axi_arready), DW'(1'b1));
    check("post_rst_awready", DW'(s_axi_awready), DW'(1'b1));
    mon_ignore = 1'b0;
    rd_exp[0]  = {{28{8'hAA}}, {4{8'hFF}}};
    read_burst(64'h100, 0);
    for (int i = 0; i < 16; i++) rd_exp[i] = DW'(32'h200 + i);
    read_burst(64'h200, 15);

    repeat (2) @(posedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
